// File: rtl/maroc_sc_loader.sv
// Collects the 829-bit MAROC slow-control frame from a host byte stream, launches
// the shift-out transmitter and follows its reported state until FINAL or timeout.
module maroc_sc_loader #(
  parameter int FRAME_BITS     = 829,
  parameter int NBYTES         = 104,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic                  clk_in,
  input  logic                  reset_n_in,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid_in,
  output logic                  byte_ready_out,
  input  logic                  frame_abort_in,
  input  logic [1:0]            tx_state_in,
  output logic                  start_out,
  output logic [FRAME_BITS-1:0] frame_out,
  output logic                  busy_out,
  output logic                  done_out,
  output logic                  error_out,
  output logic [6:0]            byte_cnt_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_LAUNCH, S_WAIT_TX, S_DONE, S_ERROR
  } state_t;

  localparam logic [6:0]  LAST_IDX   = 7'(NBYTES - 1);
  localparam logic [11:0] TMO_LAST   = 12'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  TX_SENDING = 2'd2;
  localparam logic [1:0]  TX_FINAL   = 2'd3;

  state_t      state_q, state_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        armed_q, armed_d;
  logic [11:0] tmo_q, tmo_d;
  logic        start_q;
  logic        wr_en;
  logic [6:0]  wr_idx;

  function automatic logic [11:0] sat_inc12(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

  assign byte_ready_out = (state_q != S_LAUNCH) && (state_q != S_WAIT_TX);
  assign busy_out       = (state_q == S_LAUNCH) || (state_q == S_WAIT_TX);
  assign done_out       = (state_q == S_DONE);
  assign error_out      = (state_q == S_ERROR);
  assign start_out      = start_q;
  assign byte_cnt_out   = cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    armed_d = armed_q;
    tmo_d   = tmo_q;
    wr_en   = 1'b0;
    wr_idx  = 7'd0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (byte_valid_in) begin
          wr_en   = 1'b1;
          cnt_d   = 7'd1;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        // Abort wins over a byte offered in the same cycle.
        if (frame_abort_in) begin
          cnt_d   = 7'd0;
          state_d = S_IDLE;
        end else if (byte_valid_in) begin
          wr_en  = 1'b1;
          wr_idx = cnt_q;
          cnt_d  = cnt_q + 7'd1;
          if (cnt_q == LAST_IDX) state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        tmo_d   = 12'd0;
        armed_d = 1'b0;
        state_d = S_WAIT_TX;
      end
      S_WAIT_TX: begin
        if (tx_state_in == TX_SENDING) armed_d = 1'b1;
        tmo_d = sat_inc12(tmo_q);
        // FINAL only counts once SENDING was seen; earlier FINAL is left over from the last frame.
        if (armed_q && tx_state_in == TX_FINAL) state_d = S_DONE;
        else if (tmo_q >= TMO_LAST)              state_d = S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q <= S_IDLE;
      cnt_q   <= 7'd0;
      armed_q <= 1'b0;
      tmo_q   <= 12'd0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      tmo_q   <= tmo_d;
      start_q <= (state_d == S_LAUNCH);
    end
  end

  // One register slice per byte; the last byte keeps only the bits that fit the frame.
  for (genvar k = 0; k < NBYTES; k++) begin : g_byte
    localparam int LO = 8 * k;
    localparam int W  = (FRAME_BITS - LO < 8) ? (FRAME_BITS - LO) : 8;
    logic [W-1:0] byte_q;
    always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in)                         byte_q <= '0;
      else if (wr_en && wr_idx == 7'(k))       byte_q <= byte_in[W-1:0];
    end
    assign frame_out[LO +: W] = byte_q;
  end

endmodule

// File: tb/tb_maroc_sc_loader.sv
// Scoreboard bench for maroc_sc_loader: stimulus queues expected start/done/error
// events, an independent monitor pops and checks them when the DUT raises them.
module tb_maroc_sc_loader;
  localparam int FB = 829;
  localparam int NB = 104;
  localparam int EV_START = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_ERROR = 2;

  logic          clk_in = 1'b0;
  logic          reset_n_in = 1'b0;
  logic [7:0]    byte_in = 8'd0;
  logic          byte_valid_in = 1'b0;
  logic          byte_ready_out;
  logic          frame_abort_in = 1'b0;
  logic [1:0]    tx_state_in = 2'd0;
  logic          start_out;
  logic [FB-1:0] frame_out;
  logic          busy_out, done_out, error_out;
  logic [6:0]    byte_cnt_out;

  maroc_sc_loader #(.FRAME_BITS(FB), .NBYTES(NB), .TIMEOUT_CYCLES(4095)) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in), .byte_in(byte_in),
    .byte_valid_in(byte_valid_in), .byte_ready_out(byte_ready_out),
    .frame_abort_in(frame_abort_in), .tx_state_in(tx_state_in),
    .start_out(start_out), .frame_out(frame_out), .busy_out(busy_out),
    .done_out(done_out), .error_out(error_out), .byte_cnt_out(byte_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int            kind;
    int            cyc;
    logic [FB-1:0] frame;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [831:0] act, input logic [831:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pat_byte(input int pat, input int k);
    return (pat == 0) ? 8'(k) : 8'(k * 3 + 1);
  endfunction

  function automatic logic [FB-1:0] build(input int pat);
    logic [FB-1:0] f = '0;
    logic [7:0] b;
    for (int k = 0; k < NB; k++) begin
      b = pat_byte(pat, k);
      for (int i = 0; i < 8; i++)
        if (8 * k + i < FB) f[8 * k + i] = b[i];
    end
    return f;
  endfunction

  task automatic push(input int kind, input int c, input logic [FB-1:0] f);
    exp_t e;
    e.kind = kind; e.cyc = c; e.frame = f;
    sb.push_back(e);
  endtask

  // Monitor: each DUT event consumes one scoreboard entry.
  task automatic take(input int kind);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d expected none", kind, cyc);
    end else begin
      e = sb.pop_front();
      check("event_kind", 832'(kind), 832'(e.kind));
      check("event_cycle", 832'(cyc), 832'(e.cyc));
      if (kind == EV_START) begin
        check("start_frame", 832'(frame_out), 832'(e.frame));
        check("start_ready", 832'(byte_ready_out), 832'(0));
        check("start_busy", 832'(busy_out), 832'(1));
        check("start_cnt", 832'(byte_cnt_out), 832'(NB));
      end else if (kind == EV_DONE) begin
        check("done_busy", 832'(busy_out), 832'(0));
        check("done_ready", 832'(byte_ready_out), 832'(1));
      end else begin
        check("error_busy", 832'(busy_out), 832'(0));
        check("error_done", 832'(done_out), 832'(0));
      end
    end
  endtask

  logic prev_done = 1'b0, prev_err = 1'b0;
  always @(negedge clk_in) begin
    if (!reset_n_in) begin
      prev_done <= 1'b0;
      prev_err  <= 1'b0;
    end else begin
      if (start_out)               take(EV_START);
      if (done_out && !prev_done)  take(EV_DONE);
      if (error_out && !prev_err)  take(EV_ERROR);
      prev_done <= done_out;
      prev_err  <= error_out;
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_drain(input int maxc);
    int n = 0;
    while (sb.size() != 0 && n < maxc) begin
      tick();
      n++;
    end
    check("scoreboard_drain", 832'(sb.size()), 832'(0));
  endtask

  task automatic send_frame(input int pat, input bit gaps);
    for (int k = 0; k < NB; k++) begin
      if (gaps) begin
        while ($urandom_range(0, 3) == 0) begin
          byte_valid_in = 1'b0;
          tick();
        end
      end
      byte_in = pat_byte(pat, k);
      byte_valid_in = 1'b1;
      if (k == NB - 1) push(EV_START, cyc + 1, build(pat));
      tick();
      if (k == 59) check("cnt_mid_frame", 832'(byte_cnt_out), 832'(60));
    end
    byte_valid_in = 1'b0;
  endtask

  initial begin
    int n;
    // Reset values
    repeat (3) tick();
    check("rst_start", 832'(start_out), 832'(0));
    check("rst_frame", 832'(frame_out), 832'(0));
    check("rst_cnt", 832'(byte_cnt_out), 832'(0));
    check("rst_busy", 832'(busy_out), 832'(0));
    check("rst_done", 832'(done_out), 832'(0));
    check("rst_error", 832'(error_out), 832'(0));
    check("rst_ready", 832'(byte_ready_out), 832'(1));
    reset_n_in = 1'b1;
    tick();

    // Back-to-back frame, nominal transmitter
    send_frame(0, 1'b0);
    check("launch_ready", 832'(byte_ready_out), 832'(0));
    check("launch_busy", 832'(busy_out), 832'(1));
    repeat (3) tick();
    tx_state_in = 2'd2;
    repeat (830) tick();
    check("wait_ready", 832'(byte_ready_out), 832'(0));
    push(EV_DONE, cyc + 1, '0);
    tx_state_in = 2'd3;
    repeat (2) tick();
    tx_state_in = 2'd0;
    wait_drain(50);
    check("done_level", 832'(done_out), 832'(1));
    check("frame_b0", 832'(frame_out[7:0]), 832'(8'h00));
    check("frame_b1", 832'(frame_out[15:8]), 832'(8'h01));
    check("frame_b103", 832'(frame_out[828:824]), 832'(5'h07));

    // New frame from DONE, then abort after 50 bytes
    byte_in = 8'hA5; byte_valid_in = 1'b1;
    tick();
    byte_valid_in = 1'b0;
    check("new_done_clr", 832'(done_out), 832'(0));
    check("new_cnt", 832'(byte_cnt_out), 832'(1));
    check("new_b0", 832'(frame_out[7:0]), 832'(8'hA5));
    for (int k = 1; k < 50; k++) begin
      byte_in = 8'(k) ^ 8'hFF; byte_valid_in = 1'b1;
      tick();
    end
    check("pre_abort_cnt", 832'(byte_cnt_out), 832'(50));
    byte_in = 8'hEE; byte_valid_in = 1'b1; frame_abort_in = 1'b1;
    tick();
    byte_valid_in = 1'b0; frame_abort_in = 1'b0;
    check("abort_cnt", 832'(byte_cnt_out), 832'(0));
    check("abort_b50", 832'(frame_out[407:400]), 832'(8'h32));
    check("abort_b49", 832'(frame_out[399:392]), 832'(8'hCE));
    check("abort_ready", 832'(byte_ready_out), 832'(1));
    repeat (10) tick();
    check("abort_busy", 832'(busy_out), 832'(0));

    // Gapped frame, stale FINAL held: timeout
    send_frame(0, 1'b1);
    n = cyc;
    tx_state_in = 2'd3;
    push(EV_ERROR, n + 4096, '0);
    wait_drain(4300);
    check("tmo_error", 832'(error_out), 832'(1));
    check("tmo_done", 832'(done_out), 832'(0));
    tx_state_in = 2'd0;

    // Reset during WAIT_TX
    send_frame(1, 1'b0);
    wait_drain(5);
    repeat (20) tick();
    check("wait_busy", 832'(busy_out), 832'(1));
    #2 reset_n_in = 1'b0;
    #1;
    check("arst_start", 832'(start_out), 832'(0));
    check("arst_frame", 832'(frame_out), 832'(0));
    check("arst_cnt", 832'(byte_cnt_out), 832'(0));
    check("arst_busy", 832'(busy_out), 832'(0));
    check("arst_done", 832'(done_out), 832'(0));
    check("arst_error", 832'(error_out), 832'(0));
    check("arst_ready", 832'(byte_ready_out), 832'(1));
    tick();
    reset_n_in = 1'b1;
    repeat (30) tick();
    check("post_rst_busy", 832'(busy_out), 832'(0));
    check("post_rst_cnt", 832'(byte_cnt_out), 832'(0));

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/maroc_sc_loader.md
# maroc_sc_loader

Upstream feeder for the MAROC slow-control shift-out stage. It assembles the 829-bit slow-control frame from a byte stream delivered by the host link (USB/UART bridge) using a valid/ready handshake. Once the frame is complete, it presents the frame as a flat bus, pulses the transmitter's start, and tracks the transmitter's reported state until the frame has been shifted out or a timeout expires. It shares the transmitter's 5 MHz clock.

## Interface
Parameters:
- FRAME_BITS, 829, slow-control frame length in bits
- NBYTES, 104, bytes per frame, equal to ceil(FRAME_BITS/8)
- TIMEOUT_CYCLES, 4095, maximum number of cycles from start pulse to transmitter FINAL

Ports:
- clk_in  input  1  5 MHz system clock; all logic on rising edge
- reset_n_in  input  1  asynchronous active-low reset
- byte_in  input  8  frame byte from host link
- byte_valid_in  input  1  byte_in is valid
- byte_ready_out  output  1  loader accepts a byte this cycle
- frame_abort_in  input  1  synchronous; discard a partially collected frame
- tx_state_in  input  2  transmitter state_out (0 IDLE, 1 PREPARE_TO_SEND, 2 SENDING, 3 FINAL)
- start_out  output  1  one-cycle start pulse to the transmitter's start_in
- frame_out  output  FRAME_BITS  assembled frame; bit 0 is the first bit shifted
- busy_out  output  1  high in LAUNCH and WAIT_TX
- done_out  output  1  high in DONE
- error_out  output  1  high in ERROR
- byte_cnt_out  output  7  number of bytes accepted in the current frame

## Operation
- States: IDLE, COLLECT, LAUNCH, WAIT_TX, DONE, ERROR. Reset state is IDLE.
- Byte transfer occurs when byte_valid_in and byte_ready_out are both high. byte_ready_out is combinational: 1 in IDLE, COLLECT, DONE and ERROR; 0 in LAUNCH and WAIT_TX.
- Byte k (k = 0 .. NBYTES-1) is written to frame_out[8k+7:8k]. Bits with index ≥ FRAME_BITS are dropped: for byte 103 only bits [4:0] are used (frame bits 828:824).
- IDLE, DONE or ERROR plus a transfer: store the byte as byte 0, set byte_cnt_out to 1, go to COLLECT. done_out and error_out clear on that transition.
- COLLECT plus a transfer: store the byte at index byte_cnt_out, then increment. When the accepted byte is byte NBYTES-1, go to LAUNCH; byte_cnt_out holds at NBYTES.
- frame_abort_in high in COLLECT: go to IDLE, set byte_cnt_out to 0. Abort has priority over a simultaneous transfer. Abort is ignored in all other states.
- LAUNCH lasts one cycle. start_out is 1 during it. Clear the timeout counter and the armed flag, then go to WAIT_TX.
- WAIT_TX: set armed when tx_state_in == 2. When armed and tx_state_in == 3, go to DONE. A FINAL observed before SENDING does not complete the frame; this is a stale state from the previous frame.
- The timeout counter increments every WAIT_TX cycle. When it reaches TIMEOUT_CYCLES without reaching DONE, go to ERROR.
- frame_out changes only on accepted bytes. It is stable from LAUNCH through WAIT_TX; the transmitter latches it in PREPARE_TO_SEND.
- Timeout counter width is 12 bits and saturates; there is no wrap.

## Timing
- Reset values: start_out 0, frame_out all 0, byte_cnt_out 0, busy_out 0, done_out 0, error_out 0, byte_ready_out 1 (IDLE).
- start_out is registered. It goes high in the cycle after the final byte is accepted and stays high for exactly 1 cycle.
- The transmitter's state_out lags its internal state by one cycle. Nominal sequence: tx_state_in reaches 2 about 3 cycles after start_out, and reaches 3 about 830 cycles later. done_out is 1 in the cycle after tx_state_in == 3 is sampled while armed.
- Nominal latency from last byte to done_out is about 835 cycles; TIMEOUT_CYCLES leaves ≥4x margin.
- Reset asserted mid-frame or mid-send: all state clears immediately (asynchronous reset). No start_out is generated after reset deasserts.
- byte_valid_in held high continuously: one byte per cycle in COLLECT, for 104 cycles per frame.

## Test plan
- Send bytes 0x00..0x67 back to back: frame_out[7:0]=0x00, frame_out[15:8]=0x01, frame_out[828:824]=0x67&0x1F; a single start_out pulse one cycle after the last transfer; byte_ready_out=0 until DONE.
- Transmitter model returns 2 then 3 after 830 cycles: done_out=1 one cycle after 3 is sampled; busy_out=0; a new byte 0xA5 goes to COLLECT with frame_out[7:0]=0xA5 and done_out=0.
- Transmitter model holds tx_state_in=3 (stale FINAL) throughout: no DONE; error_out=1 after 4095 WAIT_TX cycles.
- After 50 bytes, assert frame_abort_in together with byte_valid_in: byte_cnt_out=0, state IDLE, byte not stored, no start_out.
- Assert reset_n_in low during WAIT_TX: all outputs at reset values within the same cycle; no start_out after release.
- Random gaps in byte_valid_in: frame content is identical to the back-to-back case and byte_cnt_out counts only actual transfers.
